// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and mult_div_unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output mult_start, div_start, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  mult_start, div_start, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
// Optional divider: define MD_DIV_EN to build the DIV state, divider datapath and div_zero.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH:0]   acc, acc_nxt;        // Booth accumulator / division remainder
    logic [WIDTH-1:0] qreg, qreg_nxt;      // multiplier / dividend-quotient shift register
    logic             qlsb_prev, qlsb_prev_nxt;
    logic [WIDTH-1:0] opnd, opnd_nxt;      // multiplicand / divisor magnitude
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic [WIDTH-1:0] lo, lo_nxt;

    logic [WIDTH:0]   m_ext, booth_sum, booth_acc;
    logic [WIDTH-1:0] booth_q;

    // One radix-2 Booth step: add/subtract multiplicand, then arithmetic shift right
    always_comb begin
        m_ext = {opnd[WIDTH-1], opnd};
        unique case ({qreg[0], qlsb_prev})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};
    end

`ifdef MD_DIV_EN
    logic             q_neg, q_neg_nxt;
    logic             r_neg, r_neg_nxt;
    logic             div_zero, div_zero_nxt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_shift, rem_diff, div_acc;
    logic [WIDTH-1:0] div_q, quo_res, rem_res;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        a_mag = bus.a_in[WIDTH-1] ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
        b_mag = bus.b_in[WIDTH-1] ? (~bus.b_in + WIDTH'(1)) : bus.b_in;
    end

    // One restoring-division step plus the final sign correction of its result
    always_comb begin
        rem_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd};
        if (rem_diff[WIDTH]) begin
            div_acc = rem_shift;
            div_q   = {qreg[WIDTH-2:0], 1'b0};
        end else begin
            div_acc = rem_diff;
            div_q   = {qreg[WIDTH-2:0], 1'b1};
        end
        quo_res = q_neg ? (~div_q + WIDTH'(1)) : div_q;
        rem_res = r_neg ? (~div_acc[WIDTH-1:0] + WIDTH'(1)) : div_acc[WIDTH-1:0];
    end
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        acc_nxt       = acc;
        qreg_nxt      = qreg;
        qlsb_prev_nxt = qlsb_prev;
        opnd_nxt      = opnd;
        hi_nxt        = hi;
        lo_nxt        = lo;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
`ifdef MD_DIV_EN
        q_neg_nxt     = q_neg;
        r_neg_nxt     = r_neg;
        div_zero_nxt  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.mult_start) begin
                    state_nxt     = MULT;
                    cnt_nxt       = CNT_W'(WIDTH);
                    acc_nxt       = '0;
                    qreg_nxt      = bus.b_in;
                    qlsb_prev_nxt = 1'b0;
                    opnd_nxt      = bus.a_in;
                    busy_nxt      = 1'b1;
                end
`ifdef MD_DIV_EN
                else if (bus.div_start) begin
                    if (bus.b_in == '0) begin
                        div_zero_nxt = 1'b1;
                    end else begin
                        state_nxt = DIV;
                        cnt_nxt   = CNT_W'(WIDTH);
                        acc_nxt   = '0;
                        qreg_nxt  = a_mag;
                        opnd_nxt  = b_mag;
                        q_neg_nxt = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                        r_neg_nxt = bus.a_in[WIDTH-1];
                        busy_nxt  = 1'b1;
                    end
                end
`endif
            end
            MULT: begin
                acc_nxt       = booth_acc;
                qreg_nxt      = booth_q;
                qlsb_prev_nxt = qreg[0];
                cnt_nxt       = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    hi_nxt    = booth_acc[WIDTH-1:0];
                    lo_nxt    = booth_q;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
`ifdef MD_DIV_EN
            DIV: begin
                acc_nxt  = div_acc;
                qreg_nxt = div_q;
                cnt_nxt  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    hi_nxt    = rem_res;
                    lo_nxt    = quo_res;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            qreg      <= '0;
            qlsb_prev <= 1'b0;
            opnd      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef MD_DIV_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            div_zero  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            qreg      <= qreg_nxt;
            qlsb_prev <= qlsb_prev_nxt;
            opnd      <= opnd_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            hi        <= hi_nxt;
            lo        <= lo_nxt;
`ifdef MD_DIV_EN
            q_neg     <= q_neg_nxt;
            r_neg     <= r_neg_nxt;
            div_zero  <= div_zero_nxt;
`endif
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.hi_out = hi;
    assign bus.lo_out = lo;

`ifdef MD_DIV_EN
    assign bus.div_zero = div_zero;
`else
    // Without the divider, div_start has no effect and div_zero never fires
    logic unused_div_start;
    assign unused_div_start = bus.div_start;
    assign bus.div_zero     = 1'b0;
`endif
endmodule
